desynk_sweep: RTL and testbench
===============================

DESYNK_SWEEP -- requirements
Module: desynk_sweep

Interface
REQ-001 Parameter DELAY_W, default 16, width of glitch delay values in clk cycles.
REQ-002 Parameter WIDTH_W, default 8, width of glitch-width value.
REQ-003 Parameter CNT_W, default 16, width of attempt counter.
REQ-004 Parameter CLK_DIV, default 2, target clock half-period in clk cycles (>=1).
REQ-005 Parameter RESET_CYCLES, default 4, target reset pulse length in clk cycles (>=1).
REQ-006 Parameter TIMEOUT, default 1024, clk cycles allowed for ready/success (>=1).
REQ-007 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-008 io_reset_n  in  1  synchronous, active-low reset.
REQ-009 io_start  in  1  one-cycle sweep start request; io_delay_min / io_delay_max / io_delay_step  in  DELAY_W each  sweep range and increment.
REQ-010 io_glitch_width  in  WIDTH_W  clk cycles the target clock is frozen per attempt.
REQ-011 io_target_clk / io_target_reset (active-high) / io_target_power / io_target_throttle  out  1 each  target drive.
REQ-012 io_target_ready / io_target_success  in  1 each  target status, already synchronous to clk.
REQ-013 io_busy  out  1; io_done  out  1 one-cycle pulse; io_found  out  1; io_found_delay  out  DELAY_W; io_attempts  out  CNT_W.

Function
REQ-014 FSM states: IDLE, RST_TGT, WAIT_RDY, DELAY, GLITCH, OBSERVE, NEXT, DONE.
REQ-015 IDLE: io_start=1 latches all config inputs, clears io_found, io_found_delay, io_attempts, loads cur_delay=delay_min, enters RST_TGT; io_busy, io_target_power, io_target_reset are 1 on the following cycle.
REQ-016 Start with delay_min > delay_max or delay_step = 0: go to DONE directly, power stays 0, io_found=0, io_attempts=0.
REQ-017 io_start outside IDLE is ignored; config input changes while busy have no effect.
REQ-018 RST_TGT: io_target_reset=1 for exactly RESET_CYCLES cycles, then WAIT_RDY.
REQ-019 WAIT_RDY: on io_target_ready=1 go to DELAY; after TIMEOUT cycles without ready, go to NEXT (attempt counted as failure).
REQ-020 DELAY: stay exactly cur_delay cycles (0 = next cycle) then GLITCH.
REQ-021 GLITCH: io_target_throttle=1 and io_target_clk held at its current level for max(glitch_width,1) cycles, then OBSERVE; divider counter also frozen and resumes from where it stopped.
REQ-022 Outside GLITCH, io_target_clk toggles every CLK_DIV cycles while io_target_power=1; it is 0 and the divider cleared whenever power=0.
REQ-023 OBSERVE: io_target_success=1 within TIMEOUT cycles -> io_found=1, io_found_delay=cur_delay, attempts incremented, DONE; else NEXT.
REQ-024 Success asserted in the same cycle the timeout expires counts as success.
REQ-025 NEXT (one cycle): io_attempts += 1, saturating at all-ones; if cur_delay + delay_step exceeds delay_max or overflows DELAY_W, go DONE with io_found=0; else cur_delay += delay_step, go RST_TGT.
REQ-026 Target reset is reapplied every attempt; power remains 1 across attempts.
REQ-027 DONE (one cycle): io_done=1, io_busy, power and throttle drop to 0 the following cycle in IDLE; io_found, io_found_delay, io_attempts hold until next start.
REQ-028 io_busy=1 in every state except IDLE.

Reset
REQ-029 io_reset_n=0 at a clk edge forces IDLE and all outputs to 0, including io_target_reset=0 and io_found_delay=0, io_attempts=0, regardless of state; mid-sweep reset aborts with no io_done pulse.
REQ-030 Reset has priority over io_start sampled in the same cycle.

Verification
REQ-031 Defaults; min=3,max=3,step=1,width=2; ready 2 cycles after reset release, success in OBSERVE -> reset pulse 4 cycles, clk frozen 2 cycles with throttle=1, io_found=1, io_found_delay=3, io_attempts=1, one io_done pulse.
REQ-032 min=0,max=10,step=4, success never -> attempts at delays 0,4,8, io_attempts=3, io_found=0, io_done once, power 0 after.
REQ-033 Success only when cur_delay=5, min=1,max=9,step=2 -> io_found_delay=5, io_attempts=3.
REQ-034 ready never asserted, min=0,max=1,step=1 -> two WAIT_RDY timeouts of 1024 cycles, io_attempts=2, io_found=0.
REQ-035 min=7,max=2 -> io_done 2 cycles after start, power never 1; and io_reset_n=0 during GLITCH -> all outputs 0 next cycle, no io_done.
REQ-036 DELAY_W=4, min=14,max=15,step=8 -> one attempt, overflow detected, DONE, io_attempts=1.

Source files
------------

// File: rtl/desynk_sweep_if.sv
// Host / target-side signal bundle for the desynk_sweep glitch-sweep controller.
// Groups sweep configuration, target drive, target status and sweep results.
// Ports: slave = controller side, master = host/environment side.
interface desynk_sweep_if #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int CNT_W   = 16
);
  // sweep request and configuration
  logic               io_start;
  logic [DELAY_W-1:0] io_delay_min;
  logic [DELAY_W-1:0] io_delay_max;
  logic [DELAY_W-1:0] io_delay_step;
  logic [WIDTH_W-1:0] io_glitch_width;

  // target drive
  logic               io_target_clk;
  logic               io_target_reset;
  logic               io_target_power;
  logic               io_target_throttle;

  // target status, already synchronous to clk
  logic               io_target_ready;
  logic               io_target_success;

  // sweep status / result
  logic               io_busy;
  logic               io_done;
  logic               io_found;
  logic [DELAY_W-1:0] io_found_delay;
  logic [CNT_W-1:0]   io_attempts;

  modport slave (
    input  io_start, io_delay_min, io_delay_max, io_delay_step, io_glitch_width,
    input  io_target_ready, io_target_success,
    output io_target_clk, io_target_reset, io_target_power, io_target_throttle,
    output io_busy, io_done, io_found, io_found_delay, io_attempts
  );

  modport master (
    output io_start, io_delay_min, io_delay_max, io_delay_step, io_glitch_width,
    output io_target_ready, io_target_success,
    input  io_target_clk, io_target_reset, io_target_power, io_target_throttle,
    input  io_busy, io_done, io_found, io_found_delay, io_attempts
  );
endinterface

// File: rtl/desynk_sweep.sv
// Clock-glitch sweep controller: powers a target, resets it, waits for ready,
// waits cur_delay cycles, freezes the target clock for glitch_width cycles and
// watches for success; steps the delay from delay_min to delay_max.
// Ports: clk, io_reset_n (sync, active-low), bus (desynk_sweep_if.slave):
//   config/start in, target clk/reset/power/throttle out, target ready/success
//   in, busy/done/found/found_delay/attempts out. All outputs are registered.
module desynk_sweep #(
  parameter int DELAY_W      = 16,
  parameter int WIDTH_W      = 8,
  parameter int CNT_W        = 16,
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input logic           clk,
  input logic           io_reset_n,
  desynk_sweep_if.slave bus
);

  // One shared down/up counter serves reset length, ready/success timeouts,
  // the delay wait and the glitch width, so it must fit the widest of them.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int AW = (TW > RW) ? TW : RW;
  localparam int BW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam int CW = (AW > BW) ? AW : BW;
  localparam int DW = $clog2(CLK_DIV) + 1;

  typedef enum logic [2:0] {
    IDLE,
    RST_TGT,
    WAIT_RDY,
    DELAY,
    GLITCH,
    OBSERVE,
    NEXT,
    DONE
  } state_t;

  state_t             st;
  logic [CW-1:0]      cnt;
  logic [DW-1:0]      div_cnt;

  // configuration captured at start; inputs are ignored while busy
  logic [DELAY_W-1:0] cur_delay;
  logic [DELAY_W-1:0] max_q;
  logic [DELAY_W-1:0] step_q;
  logic [WIDTH_W-1:0] width_q;

  // registered outputs
  logic               tclk_q;
  logic               trst_q;
  logic               power_q;
  logic               thr_q;
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [DELAY_W-1:0] found_delay_q;
  logic [CNT_W-1:0]   attempts_q;

  // next-delay computation with one extra bit so wrap-around is caught
  logic [DELAY_W:0]   next_sum;
  logic               sweep_end;
  logic [CNT_W-1:0]   attempts_inc;
  logic [CW-1:0]      glitch_load;
  logic               cfg_bad;

  assign next_sum     = {1'b0, cur_delay} + {1'b0, step_q};
  assign sweep_end    = next_sum[DELAY_W] || (next_sum[DELAY_W-1:0] > max_q);
  assign attempts_inc = (attempts_q == '1) ? attempts_q : attempts_q + CNT_W'(1);
  // a zero glitch width still freezes the clock for one cycle
  assign glitch_load  = (width_q == '0) ? '0 : CW'(width_q) - CW'(1);
  assign cfg_bad      = (bus.io_delay_min > bus.io_delay_max) || (bus.io_delay_step == '0);

  always_ff @(posedge clk) begin
    if (!io_reset_n) begin
      st            <= IDLE;
      cnt           <= '0;
      div_cnt       <= '0;
      cur_delay     <= '0;
      max_q         <= '0;
      step_q        <= '0;
      width_q       <= '0;
      tclk_q        <= 1'b0;
      trst_q        <= 1'b0;
      power_q       <= 1'b0;
      thr_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_delay_q <= '0;
      attempts_q    <= '0;
    end else begin
      done_q <= 1'b0;

      // Target clock divider. It holds (counter and level) while the FSM sits
      // in GLITCH and picks up where it left off afterwards. Branches below
      // that drop power override it to force the clock low in the same edge.
      if (!power_q) begin
        tclk_q  <= 1'b0;
        div_cnt <= '0;
      end else if (st != GLITCH) begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          tclk_q  <= ~tclk_q;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end

      case (st)
        IDLE: begin
          if (bus.io_start) begin
            found_q       <= 1'b0;
            found_delay_q <= '0;
            attempts_q    <= '0;
            cur_delay     <= bus.io_delay_min;
            max_q         <= bus.io_delay_max;
            step_q        <= bus.io_delay_step;
            width_q       <= bus.io_glitch_width;
            busy_q        <= 1'b1;
            if (cfg_bad) begin
              // empty sweep: report done without ever powering the target
              st <= DONE;
            end else begin
              st      <= RST_TGT;
              power_q <= 1'b1;
              trst_q  <= 1'b1;
              cnt     <= CW'(RESET_CYCLES - 1);
            end
          end
        end

        RST_TGT: begin
          if (cnt == '0) begin
            trst_q <= 1'b0;
            cnt    <= '0;
            st     <= WAIT_RDY;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WAIT_RDY: begin
          if (bus.io_target_ready) begin
            if (cur_delay == '0) begin
              st    <= GLITCH;
              thr_q <= 1'b1;
              cnt   <= glitch_load;
            end else begin
              st  <= DELAY;
              cnt <= CW'(cur_delay) - CW'(1);
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            st <= NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DELAY: begin
          if (cnt == '0) begin
            st    <= GLITCH;
            thr_q <= 1'b1;
            cnt   <= glitch_load;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GLITCH: begin
          if (cnt == '0) begin
            st    <= OBSERVE;
            thr_q <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        OBSERVE: begin
          // success is tested before the timeout so a last-cycle hit counts
          if (bus.io_target_success) begin
            found_q       <= 1'b1;
            found_delay_q <= cur_delay;
            attempts_q    <= attempts_inc;
            st            <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            st <= NEXT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        NEXT: begin
          attempts_q <= attempts_inc;
          if (sweep_end) begin
            st <= DONE;
          end else begin
            cur_delay <= next_sum[DELAY_W-1:0];
            st        <= RST_TGT;
            trst_q    <= 1'b1;
            cnt       <= CW'(RESET_CYCLES - 1);
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          power_q <= 1'b0;
          thr_q   <= 1'b0;
          tclk_q  <= 1'b0;
          div_cnt <= '0;
          st      <= IDLE;
        end

        default: st <= IDLE;
      endcase
    end
  end

  assign bus.io_target_clk      = tclk_q;
  assign bus.io_target_reset    = trst_q;
  assign bus.io_target_power    = power_q;
  assign bus.io_target_throttle = thr_q;
  assign bus.io_busy            = busy_q;
  assign bus.io_done            = done_q;
  assign bus.io_found           = found_q;
  assign bus.io_found_delay     = found_delay_q;
  assign bus.io_attempts        = attempts_q;

endmodule

// File: tb/tb_desynk_sweep.sv
// Directed bench for desynk_sweep: one task per scenario, inline checks,
// expected values hand-computed from the sweep behaviour.
module tb_desynk_sweep;
  localparam int TIMEOUT      = 1024;
  localparam int RESET_CYCLES = 4;
  localparam int CLK_DIV      = 2;
  localparam int SEL_THR      = 0;
  localparam int SEL_TRST     = 1;
  localparam int SEL_DONE     = 2;
  localparam int SEL_DONE4    = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  desynk_sweep_if #(.DELAY_W(16), .WIDTH_W(8), .CNT_W(16)) bus ();
  desynk_sweep_if #(.DELAY_W(4),  .WIDTH_W(8), .CNT_W(16)) bus4 ();

  desynk_sweep #(
    .DELAY_W(16), .WIDTH_W(8), .CNT_W(16), .CLK_DIV(CLK_DIV),
    .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT)
  ) u_dut (.clk(clk), .io_reset_n(rst_n), .bus(bus));

  desynk_sweep #(
    .DELAY_W(4), .WIDTH_W(8), .CNT_W(16), .CLK_DIV(CLK_DIV),
    .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT)
  ) u_dut4 (.clk(clk), .io_reset_n(rst_n), .bus(bus4));

  function automatic logic sig_sel(input int which);
    case (which)
      SEL_THR:   return bus.io_target_throttle;
      SEL_TRST:  return bus.io_target_reset;
      SEL_DONE:  return bus.io_done;
      default:   return bus4.io_done;
    endcase
  endfunction

  // Advance negedges until the selected signal equals val; n = edges taken, -1 on expiry.
  task automatic wait_sig(input int which, input logic val, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (sig_sel(which) === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_cfg(input int dmin, input int dmax, input int dstep, input int width);
    bus.io_delay_min    = 16'(dmin);
    bus.io_delay_max    = 16'(dmax);
    bus.io_delay_step   = 16'(dstep);
    bus.io_glitch_width = 8'(width);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.io_start = 1'b1;
    @(negedge clk);
    bus.io_start = 1'b0;
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {bus.io_busy, bus.io_done, bus.io_found, bus.io_target_clk,
            bus.io_target_reset, bus.io_target_power, bus.io_target_throttle};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (ctrl_vec() !== 7'b0) $display("FAIL reset_ctrl: got %b want 0000000", ctrl_vec()); else n_pass++;
    n_chk++; if (bus.io_found_delay !== 16'd0) $display("FAIL reset_found_delay: got %0d want 0", bus.io_found_delay); else n_pass++;
    n_chk++; if (bus.io_attempts !== 16'd0) $display("FAIL reset_attempts: got %0d want 0", bus.io_attempts); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    logic clk_a;
    set_cfg(3, 3, 1, 2);
    bus.io_target_ready = 1'b0;
    bus.io_target_success = 1'b0;
    pulse_start();
    n_chk++; if ({bus.io_busy, bus.io_target_power, bus.io_target_reset} !== 3'b111)
      $display("FAIL single_start: got %b want 111", {bus.io_busy, bus.io_target_power, bus.io_target_reset}); else n_pass++;
    wait_sig(SEL_TRST, 1'b0, 20, n);
    n_chk++; if (n !== RESET_CYCLES) $display("FAIL single_reset_len: got %0d want %0d", n, RESET_CYCLES); else n_pass++;
    @(negedge clk);
    bus.io_target_ready = 1'b1;
    wait_sig(SEL_THR, 1'b1, 50, n);
    n_chk++; if (n !== 4) $display("FAIL single_delay: got %0d want 4", n); else n_pass++;
    clk_a = bus.io_target_clk;
    wait_sig(SEL_THR, 1'b0, 50, n);
    n_chk++; if (n !== 2) $display("FAIL single_glitch_len: got %0d want 2", n); else n_pass++;
    n_chk++; if (bus.io_target_clk !== clk_a) $display("FAIL single_clk_frozen: got %b want %b", bus.io_target_clk, clk_a); else n_pass++;
    bus.io_target_success = 1'b1;
    wait_sig(SEL_DONE, 1'b1, 50, n);
    n_chk++; if (n !== 2) $display("FAIL single_done_lat: got %0d want 2", n); else n_pass++;
    n_chk++; if ({bus.io_found, bus.io_found_delay, bus.io_attempts} !== {1'b1, 16'd3, 16'd1})
      $display("FAIL single_result: got found=%b delay=%0d att=%0d want 1/3/1", bus.io_found, bus.io_found_delay, bus.io_attempts); else n_pass++;
    bus.io_target_success = 1'b0;
    bus.io_target_ready = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.io_done, bus.io_busy, bus.io_target_power, bus.io_target_clk, bus.io_found} !== 5'b00001)
      $display("FAIL single_after_done: got %b want 00001", {bus.io_done, bus.io_busy, bus.io_target_power, bus.io_target_clk, bus.io_found}); else n_pass++;
  endtask

  task automatic test_sweep_hit();
    int n;
    set_cfg(1, 9, 2, 3);
    bus.io_target_ready = 1'b1;
    pulse_start();
    // new config and a second start while busy must be ignored
    set_cfg(0, 3, 1, 1);
    bus.io_start = 1'b1;
    @(negedge clk);
    bus.io_start = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (a > 0) begin
        wait_sig(SEL_TRST, 1'b1, TIMEOUT + 20, n);
        n_chk++; if (n < 0) $display("FAIL hit_reset_rise%0d: got timeout want reset", a); else n_pass++;
      end
      wait_sig(SEL_TRST, 1'b0, 20, n);
      wait_sig(SEL_THR, 1'b1, 50, n);
      n_chk++; if (n !== 2 + 2 * a) $display("FAIL hit_delay%0d: got %0d want %0d", a, n, 2 + 2 * a); else n_pass++;
    end
    wait_sig(SEL_THR, 1'b0, 20, n);
    bus.io_target_success = 1'b1;
    wait_sig(SEL_DONE, 1'b1, 50, n);
    n_chk++; if ({bus.io_found, bus.io_found_delay, bus.io_attempts} !== {1'b1, 16'd5, 16'd3})
      $display("FAIL hit_result: got found=%b delay=%0d att=%0d want 1/5/3", bus.io_found, bus.io_found_delay, bus.io_attempts); else n_pass++;
    bus.io_target_success = 1'b0;
    bus.io_target_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_invalid();
    set_cfg(7, 2, 1, 1);
    pulse_start();
    n_chk++; if ({bus.io_busy, bus.io_done, bus.io_target_power} !== 3'b100)
      $display("FAIL inv_busy: got %b want 100", {bus.io_busy, bus.io_done, bus.io_target_power}); else n_pass++;
    @(negedge clk);
    n_chk++; if ({bus.io_done, bus.io_target_power, bus.io_found, bus.io_attempts} !== {3'b100, 16'd0})
      $display("FAIL inv_done: got done=%b pwr=%b found=%b att=%0d want 1/0/0/0", bus.io_done, bus.io_target_power, bus.io_found, bus.io_attempts); else n_pass++;
    @(negedge clk);
    n_chk++; if ({bus.io_done, bus.io_busy} !== 2'b00) $display("FAIL inv_end: got %b want 00", {bus.io_done, bus.io_busy}); else n_pass++;
    set_cfg(0, 5, 0, 1);
    pulse_start();
    @(negedge clk);
    n_chk++; if ({bus.io_done, bus.io_target_power} !== 2'b10) $display("FAIL step0_done: got %b want 10", {bus.io_done, bus.io_target_power}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_sweep_miss();
    int n;
    set_cfg(0, 10, 4, 1);
    bus.io_target_ready = 1'b1;
    pulse_start();
    for (int a = 0; a < 3; a++) begin
      if (a > 0) wait_sig(SEL_TRST, 1'b1, TIMEOUT + 20, n);
      wait_sig(SEL_TRST, 1'b0, 20, n);
      wait_sig(SEL_THR, 1'b1, 50, n);
      n_chk++; if (n !== 1 + 4 * a) $display("FAIL miss_delay%0d: got %0d want %0d", a, n, 1 + 4 * a); else n_pass++;
    end
    wait_sig(SEL_DONE, 1'b1, TIMEOUT + 50, n);
    n_chk++; if (n < 0) $display("FAIL miss_done: got timeout want done"); else n_pass++;
    n_chk++; if ({bus.io_found, bus.io_attempts} !== {1'b0, 16'd3})
      $display("FAIL miss_result: got found=%b att=%0d want 0/3", bus.io_found, bus.io_attempts); else n_pass++;
    bus.io_target_ready = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.io_target_power, bus.io_busy, bus.io_done} !== 3'b000)
      $display("FAIL miss_power_off: got %b want 000", {bus.io_target_power, bus.io_busy, bus.io_done}); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int n;
    int saw_done;
    set_cfg(0, 0, 1, 5);
    bus.io_target_ready = 1'b1;
    pulse_start();
    wait_sig(SEL_THR, 1'b1, 30, n);
    n_chk++; if (n < 0) $display("FAIL abort_glitch: got timeout want throttle"); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({ctrl_vec(), bus.io_found_delay, bus.io_attempts} !== 39'd0)
      $display("FAIL abort_outputs: got ctrl=%b delay=%0d att=%0d want all 0", ctrl_vec(), bus.io_found_delay, bus.io_attempts); else n_pass++;
    rst_n = 1'b1;
    bus.io_target_ready = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.io_done === 1'b1 || bus.io_busy === 1'b1) saw_done++;
    end
    n_chk++; if (saw_done !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", saw_done); else n_pass++;
    // reset and start in the same cycle: reset wins
    set_cfg(0, 0, 1, 1);
    rst_n = 1'b0;
    bus.io_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.io_start = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.io_busy, bus.io_target_power} !== 2'b00)
      $display("FAIL rst_priority: got %b want 00", {bus.io_busy, bus.io_target_power}); else n_pass++;
  endtask

  task automatic test_ready_timeout();
    int n;
    int tog;
    logic prev;
    set_cfg(0, 1, 1, 1);
    bus.io_target_ready = 1'b0;
    pulse_start();
    wait_sig(SEL_TRST, 1'b0, 20, n);
    prev = bus.io_target_clk;
    tog = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.io_target_clk !== prev) tog++;
      prev = bus.io_target_clk;
    end
    n_chk++; if (tog !== 20 / CLK_DIV) $display("FAIL to_clk_toggles: got %0d want %0d", tog, 20 / CLK_DIV); else n_pass++;
    wait_sig(SEL_TRST, 1'b1, TIMEOUT + 20, n);
    n_chk++; if (n !== TIMEOUT + 1 - 20) $display("FAIL to_wait_len: got %0d want %0d", n, TIMEOUT + 1 - 20); else n_pass++;
    wait_sig(SEL_DONE, 1'b1, TIMEOUT + 50, n);
    n_chk++; if (n < 0) $display("FAIL to_done: got timeout want done"); else n_pass++;
    n_chk++; if ({bus.io_found, bus.io_attempts} !== {1'b0, 16'd2})
      $display("FAIL to_result: got found=%b att=%0d want 0/2", bus.io_found, bus.io_attempts); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int n;
    bus4.io_delay_min    = 4'd14;
    bus4.io_delay_max    = 4'd15;
    bus4.io_delay_step   = 4'd8;
    bus4.io_glitch_width = 8'd1;
    bus4.io_target_ready = 1'b1;
    @(negedge clk);
    bus4.io_start = 1'b1;
    @(negedge clk);
    bus4.io_start = 1'b0;
    wait_sig(SEL_DONE4, 1'b1, TIMEOUT + 100, n);
    n_chk++; if (n < 0) $display("FAIL ovf_done: got timeout want done"); else n_pass++;
    n_chk++; if ({bus4.io_found, bus4.io_attempts} !== {1'b0, 16'd1})
      $display("FAIL ovf_result: got found=%b att=%0d want 0/1", bus4.io_found, bus4.io_attempts); else n_pass++;
    bus4.io_target_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.io_start = 1'b0;
    bus.io_target_ready = 1'b0;
    bus.io_target_success = 1'b0;
    set_cfg(0, 0, 0, 0);
    bus4.io_start = 1'b0;
    bus4.io_target_ready = 1'b0;
    bus4.io_target_success = 1'b0;
    bus4.io_delay_min = 4'd0;
    bus4.io_delay_max = 4'd0;
    bus4.io_delay_step = 4'd0;
    bus4.io_glitch_width = 8'd0;

    test_reset();
    test_single();
    test_reset();
    test_sweep_hit();
    test_invalid();
    test_sweep_miss();
    test_reset_abort();
    test_ready_timeout();
    test_overflow();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
